// File: rtl/ewb_multi.sv
// Multi-entry eviction write buffer between the last-level cache and memory:
// evictions are absorbed into an age-ordered FIFO, read hits are served locally.
module ewb_multi #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ewb_read_i,
    input  logic                   ewb_write_i,
    input  logic [ADDR_W-1:0]      ewb_address_i,
    input  logic [LINE_W-1:0]      ewb_wdata_i,
    output logic [LINE_W-1:0]      ewb_rdata_o,
    output logic                   ewb_resp_o,
    output logic                   ewb_read_o,
    output logic                   ewb_write_o,
    output logic [ADDR_W-1:0]      ewb_address_o,
    output logic [LINE_W-1:0]      ewb_wdata_o,
    input  logic [LINE_W-1:0]      ewb_rdata_i,
    input  logic                   ewb_resp_i,
    output logic [$clog2(DEPTH):0] ewb_count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN
    } state_e;

    state_e            state_q, state_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [LINE_W-1:0] data_q [DEPTH];
    logic [LINE_W-1:0] data_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              resp_q, resp_d;
    logic              guard_q, guard_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;

    logic              hit;
    logic [PTR_W-1:0]  hit_idx;
    logic              busy, rd_req, wr_req, pop, push, full;
    logic              fetch_done, head_match;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == ewb_address_i)) begin
                hit     = 1'b1;
                hit_idx = PTR_W'(i);
            end
        end
    end

    // The requester keeps its request up through the pulse and the cycle after it.
    assign busy       = resp_q | guard_q;
    assign rd_req     = ewb_read_i & ~busy;
    assign wr_req     = ewb_write_i & ~ewb_read_i & ~busy;
    assign pop        = (state_q == S_DRAIN) & ewb_resp_i;
    assign fetch_done = (state_q == S_FETCH) & ewb_resp_i;
    assign full       = (count_q == CNT_W'(DEPTH));
    assign head_match = hit & (state_q == S_DRAIN) & (hit_idx == head_q);

    always_comb begin
        // NOTE: every _d signal takes its default first, so no path through this block infers a latch.
        state_d = state_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        resp_d  = 1'b0;
        rdata_d = rdata_q;
        push    = 1'b0;

        if (rd_req && hit) begin
            resp_d  = 1'b1;
            rdata_d = data_q[hit_idx];
        end

        if (wr_req) begin
            if (hit && !head_match) begin
                data_d[hit_idx] = ewb_wdata_i;
                resp_d          = 1'b1;
            end else if ((!head_match || pop) && (!full || pop)) begin
                push   = 1'b1;
                resp_d = 1'b1;
            end
        end

        // Pop before push: when full, the freed head slot is the tail slot.
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        if (push) begin
            valid_d[tail_q] = 1'b1;
            addr_d[tail_q]  = ewb_address_i;
            data_d[tail_q]  = ewb_wdata_i;
            tail_d          = tail_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (rd_req && !hit)        state_d = S_FETCH;
                else if (count_q != '0)    state_d = S_DRAIN;
            end
            S_FETCH: if (ewb_resp_i)       state_d = S_IDLE;
            S_DRAIN: if (ewb_resp_i)       state_d = S_IDLE;
            default:                       state_d = S_IDLE;
        endcase

        mem_read_d  = (state_d == S_FETCH);
        mem_write_d = (state_d == S_DRAIN);
        guard_d     = ewb_resp_o;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples its pre-edge value.
        if (rst) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            resp_q      <= 1'b0;
            guard_q     <= 1'b0;
            rdata_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            resp_q      <= resp_d;
            guard_q     <= guard_d;
            rdata_q     <= rdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    // NOTE: line storage has no reset; valid_q alone decides whether an entry means anything.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    assign ewb_resp_o  = resp_q | fetch_done;
    assign ewb_rdata_o = (state_q == S_FETCH) ? ewb_rdata_i : rdata_q;
    assign ewb_read_o  = mem_read_q;
    assign ewb_write_o = mem_write_q;
    assign ewb_count_o = count_q;

    always_comb begin
        ewb_address_o = '0;
        ewb_wdata_o   = '0;
        case (state_q)
            S_DRAIN: begin
                ewb_address_o = addr_q[head_q];
                ewb_wdata_o   = data_q[head_q];
            end
            S_FETCH: ewb_address_o = ewb_address_i;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ewb_multi.sv
// Directed bench for ewb_multi: vector table for buffer fill/lookup, hand-written
// sequences for stalls, drain order, read priority and reset mid-drain.
module tb_ewb_multi;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int LW    = 256;

    localparam logic [AW-1:0] A0 = 32'h0000_1000;
    localparam logic [AW-1:0] A1 = 32'h0000_1040;
    localparam logic [AW-1:0] A2 = 32'h0000_1080;
    localparam logic [AW-1:0] A3 = 32'h0000_10C0;
    localparam logic [AW-1:0] A4 = 32'h0000_1100;
    localparam logic [AW-1:0] B0 = 32'h0000_8000;

    localparam logic [LW-1:0] ZL = '0;
    localparam logic [LW-1:0] D0 = {8{32'hD000_0000}};
    localparam logic [LW-1:0] D1 = {8{32'hD111_0001}};
    localparam logic [LW-1:0] D2 = {8{32'hD222_0002}};
    localparam logic [LW-1:0] D3 = {8{32'hD333_0003}};
    localparam logic [LW-1:0] D4 = {8{32'hD444_0004}};
    localparam logic [LW-1:0] D9 = {8{32'hD999_0009}};
    localparam logic [LW-1:0] DB = {8{32'hDBBB_000B}};
    localparam logic [LW-1:0] MX = {8{32'hAAAA_5555}};
    localparam logic [LW-1:0] MY = {8{32'h1234_ABCD}};

    logic                   clk, rst;
    logic                   ewb_read_i, ewb_write_i;
    logic [AW-1:0]          ewb_address_i;
    logic [LW-1:0]          ewb_wdata_i;
    logic [LW-1:0]          ewb_rdata_o;
    logic                   ewb_resp_o, ewb_read_o, ewb_write_o;
    logic [AW-1:0]          ewb_address_o;
    logic [LW-1:0]          ewb_wdata_o;
    logic [LW-1:0]          ewb_rdata_i;
    logic                   ewb_resp_i;
    logic [$clog2(DEPTH):0] ewb_count_o;

    ewb_multi #(.DEPTH(DEPTH), .ADDR_W(AW), .LINE_W(LW)) dut (
        .clk           (clk),
        .rst           (rst),
        .ewb_read_i    (ewb_read_i),
        .ewb_write_i   (ewb_write_i),
        .ewb_address_i (ewb_address_i),
        .ewb_wdata_i   (ewb_wdata_i),
        .ewb_rdata_o   (ewb_rdata_o),
        .ewb_resp_o    (ewb_resp_o),
        .ewb_read_o    (ewb_read_o),
        .ewb_write_o   (ewb_write_o),
        .ewb_address_o (ewb_address_o),
        .ewb_wdata_o   (ewb_wdata_o),
        .ewb_rdata_i   (ewb_rdata_i),
        .ewb_resp_i    (ewb_resp_i),
        .ewb_count_o   (ewb_count_o)
    );

    int            pass_cnt = 0;
    int            total_cnt = 0;
    bit            mem_en;
    int            mem_lat;
    logic [LW-1:0] mem_rdata;
    logic [AW-1:0] log_addr[$];
    logic [LW-1:0] log_data[$];

    typedef struct {
        bit            is_wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
        int            exp_lat;
        logic [LW-1:0] exp_rdata;
        int            exp_count;
    } vec_t;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (!rst) assert (!(ewb_read_i && ewb_write_i)) else $error("read and write requested together");
    end

    // Memory model: answers a held request mem_lat samples after it is first seen.
    initial begin : mem_model
        int wait_cnt;
        wait_cnt    = 0;
        ewb_resp_i  = 1'b0;
        ewb_rdata_i = '0;
        forever begin
            @(posedge clk);
            #1;
            ewb_resp_i  = 1'b0;
            ewb_rdata_i = '0;
            if (rst) begin
                wait_cnt = 0;
            end else if (ewb_read_o || ewb_write_o) begin
                if (mem_en) begin
                    wait_cnt++;
                    if (wait_cnt >= mem_lat) begin
                        wait_cnt   = 0;
                        ewb_resp_i = 1'b1;
                        if (ewb_write_o) begin
                            log_addr.push_back(ewb_address_o);
                            log_data.push_back(ewb_wdata_o);
                        end else begin
                            ewb_rdata_i = mem_rdata;
                        end
                    end
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total_cnt++;
        if (act === expv) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    endtask

    task automatic check_line(input string name, input logic [LW-1:0] act, input logic [LW-1:0] expv);
        total_cnt++;
        if (act === expv) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    endtask

    // Issues one cache request at a negedge; holds it through the pulse and the cycle after.
    task automatic cache_op(input bit is_wr, input logic [AW-1:0] a, input logic [LW-1:0] d,
                            input int budget, output int lat, output logic [LW-1:0] rd,
                            output bit mem_rd_seen);
        ewb_read_i    = !is_wr;
        ewb_write_i   = is_wr;
        ewb_address_i = a;
        ewb_wdata_i   = d;
        lat           = -1;
        rd            = '0;
        mem_rd_seen   = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (ewb_read_o) mem_rd_seen = 1'b1;
            if (ewb_resp_o) begin
                lat = c;
                rd  = ewb_rdata_o;
                break;
            end
        end
        if (lat > 0) begin
            @(negedge clk);
            @(negedge clk);
        end
        ewb_read_i  = 1'b0;
        ewb_write_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        log_addr.delete();
        log_data.delete();
    endtask

    // Hold the pending request through its response pulse and the following cycle.
    task automatic hold_and_drop();
        @(negedge clk);
        @(negedge clk);
        ewb_read_i  = 1'b0;
        ewb_write_i = 1'b0;
    endtask

    initial begin : main
        vec_t          tbl[8];
        int            lat;
        logic [LW-1:0] rd;
        bit            mrd, seen, found, held;
        int            c2;
        logic [AW-1:0] exp_addr[6];
        logic [LW-1:0] exp_data[6];

        tbl[0] = '{1'b1, A0, D0, 1, ZL, 1};
        tbl[1] = '{1'b1, A1, D1, 1, ZL, 2};
        tbl[2] = '{1'b1, A1, D9, 1, ZL, 2};
        tbl[3] = '{1'b0, A1, ZL, 1, D9, 2};
        tbl[4] = '{1'b0, A0, ZL, 1, D0, 2};
        tbl[5] = '{1'b1, A2, D2, 1, ZL, 3};
        tbl[6] = '{1'b0, A2, ZL, 1, D2, 3};
        tbl[7] = '{1'b1, A3, D3, 1, ZL, 4};

        exp_addr = '{A0, A1, A2, A3, A4, A2};
        exp_data = '{D0, D9, D2, D3, D4, DB};

        ewb_read_i    = 1'b0;
        ewb_write_i   = 1'b0;
        ewb_address_i = '0;
        ewb_wdata_i   = '0;
        mem_en        = 1'b0;
        mem_lat       = 3;
        mem_rdata     = '0;
        rst           = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset_resp", 32'(ewb_resp_o), 0);
        check("reset_read_o", 32'(ewb_read_o), 0);
        check("reset_write_o", 32'(ewb_write_o), 0);
        check("reset_address_o", ewb_address_o, 0);
        check_line("reset_rdata_o", ewb_rdata_o, ZL);
        check_line("reset_wdata_o", ewb_wdata_o, ZL);
        check("reset_count", 32'(ewb_count_o), 0);
        rst = 1'b0;

        // Fill with memory unresponsive: the first drain stays in flight on A0.
        for (int i = 0; i < 8; i++) begin
            cache_op(tbl[i].is_wr, tbl[i].addr, tbl[i].data, 10, lat, rd, mrd);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].exp_lat));
            check($sformatf("vec%0d_count", i), 32'(ewb_count_o), 32'(tbl[i].exp_count));
            if (!tbl[i].is_wr) begin
                check_line($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
                check($sformatf("vec%0d_no_mem_read", i), 32'(mrd), 0);
            end
        end
        check("drain_head_write_o", 32'(ewb_write_o), 1);
        check("drain_head_addr", ewb_address_o, A0);
        check_line("drain_head_data", ewb_wdata_o, D0);

        // Full stall: A4 waits for the first pop, then is pushed in that cycle.
        ewb_write_i = 1'b1; ewb_address_i = A4; ewb_wdata_i = D4;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ewb_resp_o) seen = 1'b1;
        end
        check("full_stall_no_resp", 32'(seen), 0);
        mem_en = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ewb_resp_o) seen = 1'b1;
            if (ewb_resp_i) begin found = 1'b1; break; end
        end
        check("full_stall_pop_seen", 32'(found), 1);
        check("full_stall_no_resp_before_pop", 32'(seen), 0);
        @(negedge clk);
        check("full_stall_resp_after_pop", 32'(ewb_resp_o), 1);
        check("full_stall_count", 32'(ewb_count_o), 4);
        hold_and_drop();

        // Write matching the in-flight head stalls until the pop, then becomes a new entry.
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ewb_write_o && ewb_address_o == A2) begin found = 1'b1; break; end
        end
        check("head_a2_in_flight", 32'(found), 1);
        ewb_write_i = 1'b1; ewb_address_i = A2; ewb_wdata_i = DB;
        seen = 1'b0; found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ewb_resp_o) seen = 1'b1;
            if (ewb_resp_i) begin found = 1'b1; break; end
        end
        check("head_stall_pop_seen", 32'(found), 1);
        check("head_stall_no_resp_before_pop", 32'(seen), 0);
        @(negedge clk);
        check("head_stall_resp_after_pop", 32'(ewb_resp_o), 1);
        check("head_stall_count", 32'(ewb_count_o), 3);
        hold_and_drop();

        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (ewb_count_o == 0) begin found = 1'b1; break; end
        end
        check("drained_to_empty", 32'(found), 1);
        check("drain_write_total", 32'(log_addr.size()), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < log_addr.size()) begin
                check($sformatf("drain%0d_addr", i), log_addr[i], exp_addr[i]);
                check_line($sformatf("drain%0d_data", i), log_data[i], exp_data[i]);
            end
        end

        // Read hits, then a read miss that must wait for the in-flight drain.
        mem_en = 1'b0;
        do_reset();
        cache_op(1'b1, A0, D0, 10, lat, rd, mrd);
        cache_op(1'b1, A2, D2, 10, lat, rd, mrd);
        cache_op(1'b1, A3, D3, 10, lat, rd, mrd);
        cache_op(1'b0, A2, ZL, 10, lat, rd, mrd);
        check("hit_a2_lat", 32'(lat), 1);
        check_line("hit_a2_rdata", rd, D2);
        check("hit_a2_no_mem_read", 32'(mrd), 0);
        cache_op(1'b0, A0, ZL, 10, lat, rd, mrd);
        check_line("hit_inflight_a0_rdata", rd, D0);

        ewb_read_i = 1'b1; ewb_address_i = B0;
        seen = 1'b0; held = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ewb_read_o) seen = 1'b1;
            if (!ewb_write_o) held = 1'b0;
        end
        check("miss_waits_no_read_o", 32'(seen), 0);
        check("drain_not_abandoned", 32'(held), 1);
        mem_rdata = MX;
        mem_en    = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ewb_resp_i) begin found = 1'b1; break; end
        end
        check("miss_drain_pop_seen", 32'(found), 1);
        check("no_cache_resp_on_drain_pop", 32'(ewb_resp_o), 0);
        c2 = -1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (ewb_read_o) begin c2 = c; break; end
        end
        check("read_o_after_drain_lat", 32'(c2), 2);
        check("fetch_before_drain_write_o", 32'(ewb_write_o), 0);
        check("fetch_address_o", ewb_address_o, B0);
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ewb_resp_i) begin found = 1'b1; break; end
        end
        check("fetch_resp_i_seen", 32'(found), 1);
        check("fetch_resp_passthrough", 32'(ewb_resp_o), 1);
        check_line("fetch_rdata_passthrough", ewb_rdata_o, MX);
        check("fetch_count_kept", 32'(ewb_count_o), 2);
        check("fetch_one_drain_only", 32'(log_addr.size()), 1);
        mem_en = 1'b0;
        hold_and_drop();

        // Reset while a drain is in flight.
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ewb_write_o) begin found = 1'b1; break; end
        end
        check("second_drain_started", 32'(found), 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_resp", 32'(ewb_resp_o), 0);
        check("rst_mid_read_o", 32'(ewb_read_o), 0);
        check("rst_mid_write_o", 32'(ewb_write_o), 0);
        check("rst_mid_address_o", ewb_address_o, 0);
        check_line("rst_mid_rdata_o", ewb_rdata_o, ZL);
        check_line("rst_mid_wdata_o", ewb_wdata_o, ZL);
        check("rst_mid_count", 32'(ewb_count_o), 0);
        rst = 1'b0;
        log_addr.delete();
        log_data.delete();

        // The discarded A2 line must now miss to memory, with read_o the next cycle.
        mem_rdata = MY;
        mem_en    = 1'b1;
        ewb_read_i = 1'b1; ewb_address_i = A2;
        @(negedge clk);
        check("post_rst_miss_read_o", 32'(ewb_read_o), 1);
        check("post_rst_miss_address", ewb_address_o, A2);
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (ewb_resp_o) begin found = 1'b1; break; end
            @(negedge clk);
        end
        check("post_rst_miss_resp", 32'(found), 1);
        check_line("post_rst_miss_rdata", ewb_rdata_o, MY);
        check("post_rst_count", 32'(ewb_count_o), 0);
        hold_and_drop();
        check("post_rst_no_drain", 32'(log_addr.size()), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
